// File: rtl/router_fifo.sv
// Output buffer for one destination port of the 1x3 router. The stored header tag lets the
// read side count packet length and flag each packet's final parity byte.
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              read_enb,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_out_vld,
    output logic              pkt_done,
    output logic              full,
    output logic              empty
);

    localparam int PWIDTH = AWIDTH + 1;
    localparam int CWIDTH = DWIDTH - 1;

    logic [DWIDTH:0]   mem_q [DEPTH];
    logic [PWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [DWIDTH-1:0] data_out_q, data_out_d;
    logic              data_out_vld_q, data_out_vld_d;
    logic              pkt_done_q, pkt_done_d;
    logic              wr_accept, rd_accept;
    logic [DWIDTH:0]   rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                   (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);

    // Both requests are judged against the pre-edge flags; a flush drops them entirely.
    assign wr_accept = write_enb && !full  && !rst && !soft_reset;
    assign rd_accept = read_enb  && !empty && !rst && !soft_reset;
    assign rd_entry  = mem_q[rd_ptr_q[AWIDTH-1:0]];

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        data_out_d     = data_out_q;
        data_out_vld_d = 1'b0;
        pkt_done_d     = 1'b0;

        if (soft_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            data_out_d = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PWIDTH'(1);
            end
            if (rd_accept) begin
                rd_ptr_d       = rd_ptr_q + PWIDTH'(1);
                data_out_d     = rd_entry[DWIDTH-1:0];
                data_out_vld_d = 1'b1;
                // Header carries payload length in its upper bits; +1 accounts for parity.
                if (rd_entry[DWIDTH]) begin
                    cnt_d = {1'b0, rd_entry[DWIDTH-1:2]} + CWIDTH'(1);
                end else if (cnt_q != '0) begin
                    cnt_d      = cnt_q - CWIDTH'(1);
                    pkt_done_d = (cnt_q == CWIDTH'(1));
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            data_out_q     <= '0;
            data_out_vld_q <= 1'b0;
            pkt_done_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            data_out_q     <= data_out_d;
            data_out_vld_q <= data_out_vld_d;
            pkt_done_q     <= pkt_done_d;
        end
    end

    // NOTE: the array has no reset; entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[AWIDTH-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out     = data_out_q;
    assign data_out_vld = data_out_vld_q;
    assign pkt_done     = pkt_done_q;

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: stimulus queues expected bytes, a monitor checks them as they emerge.
module tb_router_fifo;

    typedef struct {
        logic [7:0] data;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, soft_reset, write_enb, lfd_state, read_enb;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_out_vld, pkt_done, full, empty;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    router_fifo #(.DEPTH(16), .AWIDTH(4), .DWIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_reset   (soft_reset),
        .write_enb    (write_enb),
        .lfd_state    (lfd_state),
        .data_in      (data_in),
        .read_enb     (read_enb),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .pkt_done     (pkt_done),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented byte must match the head of the expectation queue.
    always @(negedge clk) begin
        if (data_out_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h, expected no output", data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.data});
                check("pkt_done", {31'd0, pkt_done}, {31'd0, e.done});
            end
        end else begin
            check("pkt_done_idle", {31'd0, pkt_done}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        write_enb = 1'b1;
        data_in   = d;
        lfd_state = lfd;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic done);
        exp_t e;
        e.data = d;
        e.done = done;
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [7:0] d, input logic done);
        expect_byte(d, done);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
    endtask

    task automatic fill_fc();
        wr(8'hFC, 1'b1);
        for (int i = 1; i < 16; i++) wr(8'h10 + 8'(i), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
        read_enb = 1'b0; data_in = 8'h00;
        tick(); tick();
        rst = 1'b0;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_vld", {31'd0, data_out_vld}, 32'd0);
        check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);

        // Single packet: header 0D -> length 3, so cnt=4 and the 4th byte after it ends the packet.
        wr(8'h0D, 1'b1); wr(8'hA1, 1'b0); wr(8'hA2, 1'b0); wr(8'hA3, 1'b0); wr(8'h0C, 1'b0);
        check("pkt_not_empty", {31'd0, empty}, 32'd0);
        expect_byte(8'h0D, 1'b0); expect_byte(8'hA1, 1'b0); expect_byte(8'hA2, 1'b0);
        expect_byte(8'hA3, 1'b0); expect_byte(8'h0C, 1'b1);
        read_enb = 1'b1;
        repeat (5) tick();
        read_enb = 1'b0;
        check("pkt_empty", {31'd0, empty}, 32'd1);
        tick();

        // Full boundary: 16 entries fill the FIFO, a 17th write is dropped.
        fill_fc();
        check("full_after_16", {31'd0, full}, 32'd1);
        wr(8'h55, 1'b0);
        check("full_after_drop", {31'd0, full}, 32'd1);
        expect_byte(8'hFC, 1'b0);
        for (int i = 1; i < 16; i++) expect_byte(8'h10 + 8'(i), 1'b0);
        read_enb = 1'b1;
        repeat (16) tick();
        read_enb = 1'b0;
        check("drain_empty", {31'd0, empty}, 32'd1);
        tick();

        // Simultaneous read+write at full: only the read is accepted.
        fill_fc();
        check("refill_full", {31'd0, full}, 32'd1);
        expect_byte(8'hFC, 1'b0);
        read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h77;
        tick();
        read_enb = 1'b0; write_enb = 1'b0;
        check("sim_full_deassert", {31'd0, full}, 32'd0);
        for (int i = 1; i < 16; i++) expect_byte(8'h10 + 8'(i), 1'b0);
        read_enb = 1'b1;
        repeat (15) tick();
        read_enb = 1'b0;
        check("sim_full_drain_empty", {31'd0, empty}, 32'd1);
        tick();

        // Simultaneous read+write at empty: write only, no bypass.
        read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h33;
        tick();
        read_enb = 1'b0; write_enb = 1'b0;
        check("sim_empty_vld", {31'd0, data_out_vld}, 32'd0);
        check("sim_empty_not_empty", {31'd0, empty}, 32'd0);
        rd(8'h33, 1'b0);
        check("sim_empty_readback_vld", {31'd0, data_out_vld}, 32'd1);
        tick();

        // Soft reset mid-packet discards everything and clears the length counter.
        wr(8'h11, 1'b1); wr(8'h21, 1'b0); wr(8'h22, 1'b0);
        rd(8'h11, 1'b0);
        soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h99;
        tick();
        soft_reset = 1'b0; write_enb = 1'b0;
        check("srst_empty", {31'd0, empty}, 32'd1);
        check("srst_data_out", {24'd0, data_out}, 32'd0);
        check("srst_cnt", {25'd0, dut.cnt_q}, 32'd0);
        check("srst_vld", {31'd0, data_out_vld}, 32'd0);
        wr(8'h44, 1'b0);
        rd(8'h44, 1'b0);
        tick();

        // Zero-length packet: header 01 loads cnt=1, parity byte ends it; then an orphan byte.
        wr(8'h01, 1'b1); wr(8'h01, 1'b0);
        rd(8'h01, 1'b0);
        rd(8'h01, 1'b1);
        wr(8'h5A, 1'b0);
        rd(8'h5A, 1'b0);
        check("orphan_vld", {31'd0, data_out_vld}, 32'd1);
        check("orphan_cnt", {25'd0, dut.cnt_q}, 32'd0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("final_empty", {31'd0, empty}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
